// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo input port between NUM_REQ producers.
// Define ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-first priority.
module fifo_wr_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_SIZE = 32,
   parameter  int BURST_LEN = 4,
   localparam int GW        = $clog2(NUM_REQ),
   localparam int CW        = $clog2(BURST_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_rts,
   input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_rtr,
   output logic [DATA_SIZE-1:0]         fifo_inp_data,
   output logic                         fifo_inp_rts,
   input  logic                         fifo_inp_rtr,
   output logic [GW-1:0]                grant_id,
   output logic                         busy
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t               state;
   logic [GW-1:0]        last_grant;
   logic [CW-1:0]        beat_cnt;
   logic [CW-1:0]        beat_nxt;
   logic [NUM_REQ-1:0]   grant_oh;
   logic                 sel_rts;
   logic [DATA_SIZE-1:0] sel_data;
   logic                 granted;
   logic                 xfer;
   logic                 last_beat;
   logic                 pick_vld;
   logic [GW-1:0]        pick_id;

   // One-hot decode of the current grant so muxing never indexes past NUM_REQ
   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            grant_oh[i] = 1'b1;
         end
      end
   end

   // Select the granted requester's rts and data
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_data = req_data[i*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   assign sel_rts       = |(req_rts & grant_oh);
   assign granted       = (state == GRANT);
   assign busy          = granted;
   assign fifo_inp_rts  = granted & sel_rts;
   assign fifo_inp_data = granted ? sel_data : '0;
   assign req_rtr       = (granted && fifo_inp_rtr) ? grant_oh : '0;
   assign xfer          = fifo_inp_rts & fifo_inp_rtr;
   assign beat_nxt      = beat_cnt + CW'(1);
   assign last_beat     = (beat_nxt == CW'(BURST_LEN));
   assign pick_vld      = |req_rts;

`ifdef ARB_FIXED_PRIO_EN
   // Lowest-index requester always wins; high indices may starve
   always_comb begin
      pick_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rts[i]) begin
            pick_id = GW'(i);
         end
      end
   end
`else
   // First set request searching upward from the one after last_grant
   always_comb begin
      logic          found;
      logic [GW-1:0] idx;
      found   = 1'b0;
      idx     = '0;
      pick_id = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = GW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req_rts[idx]) begin
            found   = 1'b1;
            pick_id = idx;
         end
      end
   end
`endif

   // Arbitration FSM: one idle cycle to pick, then hold the grant for a burst
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         beat_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant_id <= pick_id;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (!sel_rts) begin
                  state      <= IDLE;
                  last_grant <= grant_id;
               end else if (xfer) begin
                  beat_cnt <= beat_nxt;
                  if (last_beat) begin
                     state      <= IDLE;
                     last_grant <= grant_id;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_SIZE=32, BURST_LEN=4).
// Inputs change on negedge; outputs are sampled 1ns later, well before posedge.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic [NR-1:0] req_rts;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_rtr;
   logic [DW-1:0] fifo_inp_data;
   logic          fifo_inp_rts;
   logic          fifo_inp_rtr;
   logic [1:0]    grant_id;
   logic          busy;

   int n_pass;
   int n_total;
   int cyc;
   int cnt [NR];
   int      lg_gnt [$];
   int      lg_cyc [$];
   logic [DW-1:0] lg_dat [$];

   fifo_wr_arbiter #(
      .NUM_REQ  (4),
      .DATA_SIZE(32),
      .BURST_LEN(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_rts      (req_rts),
      .req_data     (req_data),
      .req_rtr      (req_rtr),
      .fifo_inp_data(fifo_inp_data),
      .fifo_inp_rts (fifo_inp_rts),
      .fifo_inp_rtr (fifo_inp_rtr),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester i presents (i<<8) | (10 + beats already sent by i)
   function automatic logic [DW-1:0] pdat(input int i, input int n);
      return DW'((i << 8) | (10 + n));
   endfunction

   task automatic cyc_step(input logic r, input logic [NR-1:0] rts,
                           input logic rtr);
      @(negedge clk);
      rst          = r;
      req_rts      = rts;
      fifo_inp_rtr = rtr;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdat(i, cnt[i]);
      #1;
      if (!r && fifo_inp_rts && fifo_inp_rtr) begin
         lg_gnt.push_back(int'(grant_id));
         lg_dat.push_back(fifo_inp_data);
         lg_cyc.push_back(cyc);
      end
      for (int i = 0; i < NR; i++)
         if (!r && req_rtr[i] && req_rts[i]) cnt[i]++;
      cyc++;
   endtask

   task automatic do_reset();
      cyc_step(1'b1, '0, 1'b1);
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      lg_gnt.delete();
      lg_dat.delete();
      lg_cyc.delete();
      cyc = 0;
   endtask

   task automatic test_reset();
      cyc_step(1'b1, 4'hF, 1'b1);
      cyc_step(1'b1, 4'hF, 1'b1);
      n_total++;
      if (busy !== 1'b0 || fifo_inp_rts !== 1'b0)
         $display("FAIL reset_hold: busy=%b rts=%b exp 0 0", busy, fifo_inp_rts);
      else n_pass++;
      cyc_step(1'b0, 4'h0, 1'b1);
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy);
      else n_pass++;
      n_total++;
      if (fifo_inp_rts !== 1'b0) $display("FAIL reset_rts: got %b exp 0", fifo_inp_rts);
      else n_pass++;
      n_total++;
      if (req_rtr !== 4'h0) $display("FAIL reset_rtr: got %h exp 0", req_rtr);
      else n_pass++;
      n_total++;
      if (grant_id !== 2'd0) $display("FAIL reset_gid: got %0d exp 0", grant_id);
      else n_pass++;
      n_total++;
      if (fifo_inp_data !== 32'h0) $display("FAIL reset_data: got %h exp 0", fifo_inp_data);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [DW-1:0] exp_d [3];
      exp_d[0] = 32'h20A;
      exp_d[1] = 32'h20B;
      exp_d[2] = 32'h20C;
      do_reset();
      cyc_step(1'b0, 4'b0100, 1'b1);
      n_total++;
      if (busy !== 1'b0 || fifo_inp_rts !== 1'b0)
         $display("FAIL single_arb: busy=%b rts=%b exp 0 0", busy, fifo_inp_rts);
      else n_pass++;
      for (int b = 0; b < 3; b++) begin
         cyc_step(1'b0, 4'b0100, 1'b1);
         n_total++;
         if (busy !== 1'b1 || grant_id !== 2'd2 || req_rtr !== 4'b0100 ||
             fifo_inp_rts !== 1'b1 || fifo_inp_data !== exp_d[b])
            $display("FAIL single_beat%0d: busy=%b gid=%0d rtr=%b data=%h exp 1 2 0100 %h",
                     b, busy, grant_id, req_rtr, fifo_inp_data, exp_d[b]);
         else n_pass++;
      end
      cyc_step(1'b0, 4'b0000, 1'b1);
      n_total++;
      if (busy !== 1'b1 || fifo_inp_rts !== 1'b0)
         $display("FAIL single_drop: busy=%b rts=%b exp 1 0", busy, fifo_inp_rts);
      else n_pass++;
      cyc_step(1'b0, 4'b0000, 1'b1);
      n_total++;
      if (busy !== 1'b0 || grant_id !== 2'd2)
         $display("FAIL single_idle: busy=%b gid=%0d exp 0 2", busy, grant_id);
      else n_pass++;
      n_total++;
      if (lg_dat.size() != 3) $display("FAIL single_count: got %0d exp 3", lg_dat.size());
      else n_pass++;
      for (int k = 0; k < lg_dat.size() && k < 3; k++) begin
         n_total++;
         if (lg_dat[k] !== exp_d[k])
            $display("FAIL single_log%0d: got %h exp %h", k, lg_dat[k], exp_d[k]);
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      int j, b, g;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         cyc_step(1'b0, 4'hF, 1'b1);
         if (c % 5 == 0) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL rr_idle_c%0d: busy=%b exp 0", c, busy);
            else n_pass++;
         end
      end
      n_total++;
      if (lg_gnt.size() != 20) $display("FAIL rr_count: got %0d exp 20", lg_gnt.size());
      else n_pass++;
      for (int k = 0; k < lg_gnt.size() && k < 20; k++) begin
         j = k / 4;
         b = k % 4;
         g = j % 4;
         n_total++;
         if (lg_gnt[k] != g || lg_cyc[k] != 5*j + 1 + b ||
             lg_dat[k] !== pdat(g, (j/4)*4 + b))
            $display("FAIL rr_beat%0d: gid=%0d cyc=%0d data=%h exp %0d %0d %h",
                     k, lg_gnt[k], lg_cyc[k], lg_dat[k], g, 5*j+1+b,
                     pdat(g, (j/4)*4 + b));
         else n_pass++;
      end
   endtask

   task automatic test_fifo_full();
      int exp_c [4];
      exp_c[0] = 1;
      exp_c[1] = 5;
      exp_c[2] = 6;
      exp_c[3] = 7;
      do_reset();
      cyc_step(1'b0, 4'b0010, 1'b1);
      cyc_step(1'b0, 4'b0010, 1'b1);
      for (int s = 0; s < 3; s++) begin
         cyc_step(1'b0, 4'b0010, 1'b0);
         n_total++;
         if (busy !== 1'b1 || grant_id !== 2'd1 || fifo_inp_rts !== 1'b1 ||
             req_rtr !== 4'b0000 || fifo_inp_data !== 32'h10B)
            $display("FAIL full_stall%0d: busy=%b gid=%0d rts=%b rtr=%b data=%h exp 1 1 1 0000 10b",
                     s, busy, grant_id, fifo_inp_rts, req_rtr, fifo_inp_data);
         else n_pass++;
      end
      for (int s = 0; s < 3; s++) cyc_step(1'b0, 4'b0010, 1'b1);
      cyc_step(1'b0, 4'b0000, 1'b1);
      n_total++;
      if (busy !== 1'b0) $display("FAIL full_release: busy=%b exp 0", busy);
      else n_pass++;
      n_total++;
      if (lg_dat.size() != 4) $display("FAIL full_count: got %0d exp 4", lg_dat.size());
      else n_pass++;
      for (int k = 0; k < lg_dat.size() && k < 4; k++) begin
         n_total++;
         if (lg_cyc[k] != exp_c[k] || lg_dat[k] !== pdat(1, k))
            $display("FAIL full_beat%0d: cyc=%0d data=%h exp %0d %h",
                     k, lg_cyc[k], lg_dat[k], exp_c[k], pdat(1, k));
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      int n3;
      do_reset();
      cyc_step(1'b0, 4'b0010, 1'b1);
      cyc_step(1'b0, 4'b0010, 1'b1);
      cyc_step(1'b0, 4'b0000, 1'b1);
      cyc_step(1'b0, 4'b1000, 1'b1);
      cyc_step(1'b0, 4'b1000, 1'b1);
      cyc_step(1'b0, 4'b1000, 1'b1);
      cyc_step(1'b1, 4'b1110, 1'b1);
      cyc_step(1'b0, 4'b1110, 1'b1);
      n_total++;
      if (busy !== 1'b0 || fifo_inp_rts !== 1'b0 || req_rtr !== 4'h0 ||
          grant_id !== 2'd0 || fifo_inp_data !== 32'h0)
         $display("FAIL mrst_idle: busy=%b rts=%b rtr=%b gid=%0d data=%h exp all 0",
                  busy, fifo_inp_rts, req_rtr, grant_id, fifo_inp_data);
      else n_pass++;
      cyc_step(1'b0, 4'b1110, 1'b1);
      n_total++;
      if (busy !== 1'b1 || grant_id !== 2'd1 || req_rtr !== 4'b0010)
         $display("FAIL mrst_regrant: busy=%b gid=%0d rtr=%b exp 1 1 0010",
                  busy, grant_id, req_rtr);
      else n_pass++;
      n3 = 0;
      foreach (lg_gnt[k]) if (lg_gnt[k] == 3) n3++;
      n_total++;
      if (n3 != 2) $display("FAIL mrst_beats3: got %0d exp 2", n3);
      else n_pass++;
   endtask

   task automatic test_prio();
      int j, b, g, n;
      do_reset();
      for (int c = 0; c < 25; c++) cyc_step(1'b0, 4'b0101, 1'b1);
      n_total++;
      if (lg_gnt.size() != 20) $display("FAIL prio_count: got %0d exp 20", lg_gnt.size());
      else n_pass++;
      for (int k = 0; k < lg_gnt.size() && k < 20; k++) begin
         j = k / 4;
         b = k % 4;
`ifdef ARB_FIXED_PRIO_EN
         g = 0;
         n = j*4 + b;
`else
         g = (j % 2 == 1) ? 2 : 0;
         n = (j/2)*4 + b;
`endif
         n_total++;
         if (lg_gnt[k] != g || lg_cyc[k] != 5*j + 1 + b || lg_dat[k] !== pdat(g, n))
            $display("FAIL prio_beat%0d: gid=%0d cyc=%0d data=%h exp %0d %0d %h",
                     k, lg_gnt[k], lg_cyc[k], lg_dat[k], g, 5*j+1+b, pdat(g, n));
         else n_pass++;
      end
   endtask

   initial begin
      n_pass       = 0;
      n_total      = 0;
      cyc          = 0;
      rst          = 1'b1;
      req_rts      = '0;
      req_data     = '0;
      fifo_inp_rtr = 1'b1;
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_fifo_full();
      test_mid_reset();
      test_prio();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
